// File: rtl/invaders_controller_pkg.sv
// rtl/invaders_controller_pkg.sv - shared gameplay codes, formation sizes and controller states
// Used by the invaders controller and the gameplay status block so both agree
// on the gameplay encoding and the formation geometry.
package invaders_controller_pkg;

  localparam logic [1:0] PLAYING   = 2'b00;
  localparam logic [1:0] YOU_WIN   = 2'b01;
  localparam logic [1:0] GAME_OVER = 2'b10;

  localparam int N_INVADERS       = 20;
  localparam int INVADERS_PER_ROW = 10;
  localparam int LINE_LAST        = 14;

  typedef enum logic [1:0] {
    RUN_RIGHT = 2'd0,
    RUN_LEFT  = 2'd1,
    HALTED    = 2'd2
  } formation_state_e;

endpackage

// File: rtl/invaders_controller_step_timer.sv
// rtl/invaders_controller_step_timer.sv - MOVE_DIV cycle divider with enable and synchronous clear
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_en             : count while high
//   i_clr            : synchronous clear to 0 (wins over i_en)
//   o_tick           : high in the wrap cycle (count == MOVE_DIV-1 while enabled)
module invaders_controller_step_timer #(
  parameter int MOVE_DIV = 12500000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = i_en && (cnt_q == CW'(MOVE_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/invaders_controller.sv
// rtl/invaders_controller.sv - invader formation state: alive mask, descent line, offset, direction
// Ports:
//   i_clk_25MHz, i_reset_n : clock, asynchronous active-low reset
//   i_gameplay             : 00 PLAYING, 01 YOU_WIN, 10 GAME_OVER; non-PLAYING freezes the formation
//   i_hit_valid/i_hit_index: one-cycle hit strobe and invader index (row*10 + column)
//   o_invaders_array       : alive mask, bit i = invader i alive
//   o_invaders_line        : descent line
//   o_invaders_x           : horizontal offset
//   o_direction            : 0 marching right, 1 marching left
//   o_step                 : one-cycle pulse when the position outputs change
//   o_hit_ack              : one-cycle pulse when a hit cleared a mask bit
module invaders_controller #(
  parameter int MOVE_DIV   = 12500000,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 15,
  parameter int LINE_START = 1,
  parameter int LINE_LAST  = invaders_controller_pkg::LINE_LAST
) (
  input  logic        i_clk_25MHz,
  input  logic        i_reset_n,
  input  logic [1:0]  i_gameplay,
  input  logic        i_hit_valid,
  input  logic [4:0]  i_hit_index,
  output logic [19:0] o_invaders_array,
  output logic [3:0]  o_invaders_line,
  output logic [4:0]  o_invaders_x,
  output logic        o_direction,
  output logic        o_step,
  output logic        o_hit_ack
);

  import invaders_controller_pkg::*;

  formation_state_e state_q, state_d;
  logic [19:0] mask_q, mask_d;
  logic [3:0]  line_q, line_d;
  logic [4:0]  x_q, x_d;
  logic        dir_q, dir_d;
  logic        step_q, step_d;
  logic        ack_q, ack_d;
  logic        running;
  logic        tick;

  assign running = (state_q != HALTED);

  invaders_controller_step_timer #(
    .MOVE_DIV (MOVE_DIV)
  ) u_step_timer (
    .i_clk     (i_clk_25MHz),
    .i_reset_n (i_reset_n),
    .i_en      (running),
    .i_clr     (!running),
    .o_tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    line_d  = line_q;
    x_d     = x_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    ack_d   = 1'b0;

    if (running && tick) begin
      step_d = 1'b1;
      // At an edge the formation descends one line (saturating) and turns around.
      if (state_q == RUN_RIGHT) begin
        if (x_q == 5'(X_MAX)) begin
          line_d  = (line_q >= 4'(LINE_LAST)) ? 4'(LINE_LAST) : line_q + 4'd1;
          dir_d   = 1'b1;
          state_d = RUN_LEFT;
        end else begin
          x_d = x_q + 5'd1;
        end
      end else begin
        if (x_q == 5'(X_MIN)) begin
          line_d  = (line_q >= 4'(LINE_LAST)) ? 4'(LINE_LAST) : line_q + 4'd1;
          dir_d   = 1'b0;
          state_d = RUN_RIGHT;
        end else begin
          x_d = x_q - 5'd1;
        end
      end
    end

    if (running && i_hit_valid && (i_hit_index < 5'(N_INVADERS))) begin
      if (mask_q[i_hit_index]) begin
        mask_d[i_hit_index] = 1'b0;
        ack_d               = 1'b1;
      end
    end

    // The current step/hit still lands; freezing starts next cycle.
    if (i_gameplay != PLAYING) begin
      state_d = HALTED;
    end
  end

  always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= RUN_RIGHT;
      mask_q  <= 20'hFFFFF;
      line_q  <= 4'(LINE_START);
      x_q     <= 5'(X_MIN);
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      line_q  <= line_d;
      x_q     <= x_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      ack_q   <= ack_d;
    end
  end

  assign o_invaders_array = mask_q;
  assign o_invaders_line  = line_q;
  assign o_invaders_x     = x_q;
  assign o_direction      = dir_q;
  assign o_step           = step_q;
  assign o_hit_ack        = ack_q;

endmodule

// File: tb/tb_invaders_controller.sv
// tb/tb_invaders_controller.sv - self-checking bench for invaders_controller
module tb_invaders_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  gameplay = 2'b00;
  logic        hit_valid = 1'b0;
  logic [4:0]  hit_index = 5'd0;
  logic [19:0] o_array;
  logic [3:0]  o_line;
  logic [4:0]  o_x;
  logic        o_dir, o_step, o_ack;

  invaders_controller #(
    .MOVE_DIV   (4),
    .X_MIN      (0),
    .X_MAX      (3),
    .LINE_START (1),
    .LINE_LAST  (14)
  ) dut (
    .i_clk_25MHz      (clk),
    .i_reset_n        (rst_n),
    .i_gameplay       (gameplay),
    .i_hit_valid      (hit_valid),
    .i_hit_index      (hit_index),
    .o_invaders_array (o_array),
    .o_invaders_line  (o_line),
    .o_invaders_x     (o_x),
    .o_direction      (o_dir),
    .o_step           (o_step),
    .o_hit_ack        (o_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] mask;
    logic [3:0]  line;
    logic [4:0]  x;
    logic        dir;
    logic        step;
    logic        ack;
  } exp_t;

  typedef struct {
    logic [4:0]  idx;
    logic        ack;
    logic [19:0] mask;
  } hit_vec_t;

  exp_t sb_q[$];
  hit_vec_t hit_tab[4];

  int checks = 0;
  int errors = 0;
  int step_seen = 0;
  int toggles = 0;
  logic prev_dir = 1'b0;

  // Reference model of the formation
  int          m_cnt;
  logic [19:0] m_mask;
  logic [3:0]  m_line;
  logic [4:0]  m_x;
  logic        m_dir;
  logic        m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mask = 20'hFFFFF; m_line = 4'd1; m_x = 5'd0; m_dir = 1'b0; m_halt = 1'b0;
    prev_dir = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_array"}, 32'(o_array), 32'hFFFFF);
    chk({tag, "_line"},  32'(o_line),  32'd1);
    chk({tag, "_x"},     32'(o_x),     32'd0);
    chk({tag, "_dir"},   32'(o_dir),   32'd0);
    chk({tag, "_step"},  32'(o_step),  32'd0);
    chk({tag, "_ack"},   32'(o_ack),   32'd0);
  endtask

  task automatic edge_turn();
    m_line = (m_line >= 4'd14) ? 4'd14 : m_line + 4'd1;
    m_dir  = ~m_dir;
  endtask

  // One clock: drive inputs, push the model's prediction, clock, pop and compare.
  task automatic cyc(input logic hv, input logic [4:0] idx, input logic [1:0] gp);
    exp_t e;
    hit_valid = hv; hit_index = idx; gameplay = gp;
    e.step = 1'b0; e.ack = 1'b0;
    if (!m_halt) begin
      if (m_cnt == 3) begin
        e.step = 1'b1;
        if (!m_dir) begin
          if (m_x == 5'd3) edge_turn(); else m_x = m_x + 5'd1;
        end else begin
          if (m_x == 5'd0) edge_turn(); else m_x = m_x - 5'd1;
        end
      end
      if (hv && idx < 5'd20) begin
        if (m_mask[idx]) begin
          m_mask[idx] = 1'b0;
          e.ack = 1'b1;
        end
      end
      m_cnt = (m_cnt == 3) ? 0 : m_cnt + 1;
    end else begin
      m_cnt = 0;
    end
    if (gp != 2'b00) m_halt = 1'b1;
    e.mask = m_mask; e.line = m_line; e.x = m_x; e.dir = m_dir;
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk("sb_array", 32'(o_array), 32'(e.mask));
    chk("sb_line",  32'(o_line),  32'(e.line));
    chk("sb_x",     32'(o_x),     32'(e.x));
    chk("sb_dir",   32'(o_dir),   32'(e.dir));
    chk("sb_step",  32'(o_step),  32'(e.step));
    chk("sb_ack",   32'(o_ack),   32'(e.ack));
    if (o_step === 1'b1) step_seen++;
    if (o_dir !== prev_dir) toggles++;
    prev_dir = o_dir;
    hit_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] hx;
    logic [3:0] hl;
    int steps0;

    hit_tab[0] = '{5'd5,  1'b1, 20'hFFFDF};
    hit_tab[1] = '{5'd5,  1'b0, 20'hFFFDF};
    hit_tab[2] = '{5'd25, 1'b0, 20'hFFFDF};
    hit_tab[3] = '{5'd19, 1'b1, 20'h7FFDF};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // Marching right, then the first edge descent, then one step left
    step_seen = 0;
    repeat (12) cyc(1'b0, 5'd0, 2'b00);
    chk("steps_12", 32'(step_seen), 32'd3);
    chk("x_after_12", 32'(o_x), 32'd3);
    repeat (4) cyc(1'b0, 5'd0, 2'b00);
    chk("c16_line", 32'(o_line), 32'd2);
    chk("c16_x",    32'(o_x),    32'd3);
    chk("c16_dir",  32'(o_dir),  32'd1);
    repeat (4) cyc(1'b0, 5'd0, 2'b00);
    chk("c20_x", 32'(o_x), 32'd2);

    // Hit vectors
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, hit_tab[i].idx, 2'b00);
      chk("tab_ack",  32'(o_ack),   32'(hit_tab[i].ack));
      chk("tab_mask", 32'(o_array), 32'(hit_tab[i].mask));
    end

    // Hit coinciding with a counter wrap
    for (int i = 0; i < 8 && m_cnt != 3; i++) cyc(1'b0, 5'd0, 2'b00);
    cyc(1'b1, 5'd0, 2'b00);
    chk("coinc_step", 32'(o_step),  32'd1);
    chk("coinc_ack",  32'(o_ack),   32'd1);
    chk("coinc_mask", 32'(o_array), 32'h7FFDE);
    chk("coinc_x",    32'(o_x),     32'd0);

    // Halt on YOU_WIN; stays halted after gameplay returns to PLAYING
    cyc(1'b0, 5'd0, 2'b01);
    hx = o_x; hl = o_line;
    steps0 = step_seen;
    for (int i = 0; i < 40; i++) cyc((i % 5) == 0, 5'd3, 2'b01);
    chk("halt_steps", 32'(step_seen - steps0), 32'd0);
    chk("halt_x",     32'(o_x),     32'(hx));
    chk("halt_line",  32'(o_line),  32'(hl));
    chk("halt_bit3",  32'(o_array[3]), 32'd1);
    for (int i = 0; i < 10; i++) cyc(i == 2, 5'd3, 2'b00);
    chk("rehalt_steps", 32'(step_seen - steps0), 32'd0);
    chk("rehalt_x",     32'(o_x),     32'(hx));
    chk("rehalt_mask",  32'(o_array), 32'h7FFDE);

    // Reset pulse leaves HALTED
    #2 rst_n = 1'b0;
    #1 check_reset("halt_reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Descend to the last line and keep turning there
    toggles = 0;
    for (int i = 0; i < 400 && o_line != 4'd14; i++) cyc(1'b0, 5'd0, 2'b00);
    chk("land_line",    32'(o_line),  32'd14);
    chk("land_toggles", 32'(toggles), 32'd13);
    toggles = 0;
    repeat (80) cyc(1'b0, 5'd0, 2'b00);
    chk("sat_line",    32'(o_line), 32'd14);
    chk("sat_toggles", 32'(toggles >= 2), 32'd1);

    // Asynchronous reset mid-count, no clock edge in between
    cyc(1'b0, 5'd0, 2'b00);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
